// File: rtl/freq_meas_ctrl_pkg.sv
// Shared definitions for the frequency measurement controller and its divider.
// Holds the FSM encoding, divider widths and the cause codes behind O_err.
package freq_meas_ctrl_pkg;

   localparam int DIV_DVD_W = 64;
   localparam int DIV_DVS_W = 32;
   localparam int DIV_ITER  = 64;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SNAP,
      ST_START,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_SETTLE,
      ST_CALC,
      ST_DIV,
      ST_POST
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_DF0_ZERO,
      ERR_TIMEOUT,
      ERR_SAT
   } err_t;

endpackage

// File: rtl/freq_meas_ctrl_seq_div_u64.sv
// Restoring divider, 64-bit dividend / 32-bit divisor, one quotient bit per cycle.
// Start is taken only while idle; done pulses one cycle after the 64th iteration.
module seq_div_u64
   import freq_meas_ctrl_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIV_DVD_W-1:0] dividend,
   input  logic [DIV_DVS_W-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [DIV_DVD_W-1:0] quotient
);

   logic [DIV_DVS_W-1:0] r_rem;
   logic [DIV_DVS_W-1:0] r_dvs;
   logic [DIV_DVD_W-1:0] r_qd;
   logic [6:0]           r_cnt;
   logic                 r_busy;
   logic                 r_done;

   logic [DIV_DVS_W:0]   w_trial;
   logic [DIV_DVS_W-1:0] w_diff;
   logic                 w_ge;

   // Remainder stays below the divisor, so the trial fits 33 bits and the
   // difference, when taken, always fits back into 32.
   assign w_trial = {r_rem, r_qd[DIV_DVD_W-1]};
   assign w_ge    = (w_trial >= {1'b0, r_dvs});
   assign w_diff  = w_trial[DIV_DVS_W-1:0] - r_dvs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem  <= '0;
         r_dvs  <= '0;
         r_qd   <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (start && !r_busy) begin
            r_qd   <= dividend;
            r_dvs  <= divisor;
            r_rem  <= '0;
            r_cnt  <= 7'(DIV_ITER);
            r_busy <= 1'b1;
         end else if (r_busy) begin
            r_rem <= w_ge ? w_diff : w_trial[DIV_DVS_W-1:0];
            r_qd  <= {r_qd[DIV_DVD_W-2:0], w_ge};
            r_cnt <= r_cnt - 7'd1;
            if (r_cnt == 7'd1) begin
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
         end
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign quotient = r_qd;

endmodule

// File: rtl/freq_meas_ctrl.sv
// Sys-domain initiator for the gated counter: start, await done, delta counts, convert to Hz.
// O_valid pulses SETTLE_CYC+68 cycles after done_s is seen high; no backpressure, results just overwrite.
module freq_meas_ctrl
   import freq_meas_ctrl_pkg::*;
#(
   parameter int unsigned REF_HZ      = 50_000_000,
   parameter int unsigned START_W     = 4,
   parameter int unsigned SETTLE_CYC  = 8,
   parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
   input  logic        I_sys_clk,
   input  logic        I_rst_n,
   input  logic        I_single,
   input  logic        I_cont,
   output logic        O_meas_start,
   input  logic        I_meas_done,
   input  logic [31:0] I_f0_cnt,
   input  logic [31:0] I_fx_cnt,
   output logic [31:0] O_freq_hz,
   output logic        O_valid,
   output logic        O_err,
   output logic        O_busy
);

   state_t               r_state;
   logic                 r_done_s1;
   logic                 r_done_s2;
   logic                 r_single_d;
   logic [31:0]          r_cnt;
   logic [31:0]          r_tmo;
   logic [31:0]          r_prev_f0;
   logic [31:0]          r_prev_fx;
   logic [DIV_DVD_W-1:0] r_num;
   logic [DIV_DVS_W-1:0] r_den;
   logic                 r_div_start;
   logic                 r_meas_start;
   logic                 r_busy;
   logic                 r_valid;
   logic [31:0]          r_freq;
   err_t                 r_cause;

   logic [31:0]          w_df0;
   logic [31:0]          w_dfx;
   logic [DIV_DVD_W-1:0] w_num;
   logic                 w_single_rise;
   logic                 w_tmo_hit;
   logic                 w_div_busy;
   logic                 w_div_done;
   logic [DIV_DVD_W-1:0] w_div_q;

   // Accumulators are free-running; modular subtraction handles wrap.
   assign w_df0         = I_f0_cnt - r_prev_f0;
   assign w_dfx         = I_fx_cnt - r_prev_fx;
   assign w_num         = 64'(REF_HZ) * {32'd0, w_dfx} + {33'd0, w_df0[31:1]};
   assign w_single_rise = I_single & ~r_single_d;
   assign w_tmo_hit     = (TIMEOUT_CYC != 0) && (r_tmo == 32'(TIMEOUT_CYC - 1));

   seq_div_u64 u_div (
      .clk      (I_sys_clk),
      .rst_n    (I_rst_n),
      .start    (r_div_start),
      .dividend (r_num),
      .divisor  (r_den),
      .busy     (w_div_busy),
      .done     (w_div_done),
      .quotient (w_div_q)
   );

   always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_state      <= ST_IDLE;
         r_done_s1    <= 1'b0;
         r_done_s2    <= 1'b0;
         r_single_d   <= 1'b0;
         r_cnt        <= '0;
         r_tmo        <= '0;
         r_prev_f0    <= '0;
         r_prev_fx    <= '0;
         r_num        <= '0;
         r_den        <= '0;
         r_div_start  <= 1'b0;
         r_meas_start <= 1'b0;
         r_busy       <= 1'b0;
         r_valid      <= 1'b0;
         r_freq       <= '0;
         r_cause      <= ERR_NONE;
      end else begin
         r_done_s1  <= I_meas_done;
         r_done_s2  <= r_done_s1;
         r_single_d <= I_single;
         r_valid    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_single_rise || I_cont) begin
                  r_busy  <= 1'b1;
                  r_state <= ST_SNAP;
               end
            end
            ST_SNAP: begin
               r_prev_f0    <= I_f0_cnt;
               r_prev_fx    <= I_fx_cnt;
               r_tmo        <= '0;
               r_cnt        <= 32'(START_W - 1);
               r_meas_start <= 1'b1;
               r_state      <= ST_START;
            end
            ST_START: begin
               r_tmo <= r_tmo + 32'd1;
               if (w_tmo_hit) begin
                  r_meas_start <= 1'b0;
                  r_freq       <= '0;
                  r_cause      <= ERR_TIMEOUT;
                  r_valid      <= 1'b1;
                  r_state      <= ST_POST;
               end else if (r_cnt == 32'd0) begin
                  r_meas_start <= 1'b0;
                  r_state      <= ST_WAIT_LO;
               end else begin
                  r_cnt <= r_cnt - 32'd1;
               end
            end
            // A done left high by the previous run must clear before we look for completion.
            ST_WAIT_LO: begin
               r_tmo <= r_tmo + 32'd1;
               if (w_tmo_hit) begin
                  r_freq  <= '0;
                  r_cause <= ERR_TIMEOUT;
                  r_valid <= 1'b1;
                  r_state <= ST_POST;
               end else if (!r_done_s2) begin
                  r_state <= ST_WAIT_HI;
               end
            end
            ST_WAIT_HI: begin
               r_tmo <= r_tmo + 32'd1;
               if (r_done_s2) begin
                  r_cnt   <= 32'(SETTLE_CYC - 1);
                  r_state <= ST_SETTLE;
               end else if (w_tmo_hit) begin
                  r_freq  <= '0;
                  r_cause <= ERR_TIMEOUT;
                  r_valid <= 1'b1;
                  r_state <= ST_POST;
               end
            end
            ST_SETTLE: begin
               if (r_cnt == 32'd0) r_state <= ST_CALC;
               else                r_cnt   <= r_cnt - 32'd1;
            end
            ST_CALC: begin
               if (w_df0 == 32'd0) begin
                  r_freq  <= '0;
                  r_cause <= ERR_DF0_ZERO;
                  r_valid <= 1'b1;
                  r_state <= ST_POST;
               end else begin
                  r_num       <= w_num;
                  r_den       <= w_df0;
                  r_div_start <= 1'b1;
                  r_state     <= ST_DIV;
               end
            end
            ST_DIV: begin
               if (w_div_busy) r_div_start <= 1'b0;
               if (w_div_done) begin
                  if (|w_div_q[63:32]) begin
                     r_freq  <= 32'hFFFF_FFFF;
                     r_cause <= ERR_SAT;
                  end else begin
                     r_freq  <= w_div_q[31:0];
                     r_cause <= ERR_NONE;
                  end
                  r_valid <= 1'b1;
                  r_state <= ST_POST;
               end
            end
            ST_POST: begin
               if (I_cont) begin
                  r_state <= ST_SNAP;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign O_meas_start = r_meas_start;
   assign O_freq_hz    = r_freq;
   assign O_valid      = r_valid;
   assign O_err        = (r_cause != ERR_NONE);
   assign O_busy       = r_busy;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Scoreboard bench: an emulated counter drives done/accumulators, a reference model predicts each post.
module tb_freq_meas_ctrl;

   localparam int unsigned REF     = 50_000_000;
   localparam int unsigned START_W = 4;
   localparam int unsigned SETTLE  = 8;
   localparam int unsigned TMO     = 1000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        single = 1'b0;
   logic        cont = 1'b0;
   logic        done = 1'b0;
   logic [31:0] f0 = '0;
   logic [31:0] fx = '0;
   logic        O_meas_start;
   logic [31:0] O_freq_hz;
   logic        O_valid;
   logic        O_err;
   logic        O_busy;

   typedef struct packed {
      logic [31:0] f;
      logic        e;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   n_valid = 0;
   int   n_exp = 0;
   int   cyc = 0;
   int   sw = 0;

   freq_meas_ctrl #(
      .REF_HZ      (REF),
      .START_W     (START_W),
      .SETTLE_CYC  (SETTLE),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .I_sys_clk    (clk),
      .I_rst_n      (rst_n),
      .I_single     (single),
      .I_cont       (cont),
      .O_meas_start (O_meas_start),
      .I_meas_done  (done),
      .I_f0_cnt     (f0),
      .I_fx_cnt     (fx),
      .O_freq_hz    (O_freq_hz),
      .O_valid      (O_valid),
      .O_err        (O_err),
      .O_busy       (O_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // freq = round(REF * dFx / dF0), saturating; dF0 == 0 is an error.
   function automatic exp_t model(input logic [31:0] df0, input logic [31:0] dfx);
      longint unsigned num;
      longint unsigned q;
      exp_t r;
      if (df0 == 0) begin
         r = '{f: 32'd0, e: 1'b1};
      end else begin
         num = longint'(REF) * longint'(dfx) + longint'(df0 / 2);
         q   = num / longint'(df0);
         if (q > 64'hFFFF_FFFF) r = '{f: 32'hFFFF_FFFF, e: 1'b1};
         else                   r = '{f: q[31:0], e: 1'b0};
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && O_valid === 1'b1) begin
         exp_t e;
         n_valid++;
         chk("valid_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("freq_hz", 64'(O_freq_hz), 64'(e.f));
            chk("err", 64'(O_err), 64'(e.e));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) sw = 0;
      else if (O_meas_start === 1'b1) sw++;
      else if (sw != 0) begin
         chk("start_width", 64'(sw), 64'(START_W));
         sw = 0;
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_start(output bit ok, output int c0);
      ok = 1'b0;
      c0 = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (O_meas_start === 1'b1) begin
            ok = 1'b1;
            c0 = cyc;
            return;
         end
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (O_valid === 1'b1) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (O_busy === 1'b0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic pulse_single();
      @(posedge clk); #1 single = 1'b1;
      repeat (2) @(posedge clk);
      #1 single = 1'b0;
   endtask

   // Emulated counter: old done lingers after start, accumulators advance, then done rises.
   task automatic do_run(input logic [31:0] df0, input logic [31:0] dfx, input int stale,
                         input bit never_done, input bit use_single, input bit push,
                         input bit drop_cont, output int c0);
      bit   ok;
      exp_t e;
      if (use_single) pulse_single();
      wait_start(ok, c0);
      chk("start_seen", 64'(ok), 64'd1);
      if (!ok) return;
      if (drop_cont) cont = 1'b0;
      repeat (stale) @(posedge clk);
      #1 done = 1'b0;
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1 f0 = f0 + df0;
      fx = fx + dfx;
      if (never_done) begin
         e = '{f: 32'd0, e: 1'b1};
         sb.push_back(e);
         n_exp++;
         return;
      end
      e = model(df0, dfx);
      repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
      if (push) begin
         sb.push_back(e);
         n_exp++;
      end
      done = 1'b1;
   endtask

   task automatic finish_run(input int budget);
      bit ok;
      wait_valid(budget, ok);
      chk("valid_seen", 64'(ok), 64'd1);
      wait_idle(ok);
      chk("idle_after_post", 64'(ok), 64'd1);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_freq"}, 64'(O_freq_hz), 64'd0);
      chk({tag, "_err"}, 64'(O_err), 64'd0);
      chk({tag, "_valid"}, 64'(O_valid), 64'd0);
      chk({tag, "_busy"}, 64'(O_busy), 64'd0);
      chk({tag, "_start"}, 64'(O_meas_start), 64'd0);
   endtask

   initial begin
      int  c0;
      bit  ok;
      logic [31:0] rdf0;

      repeat (3) @(posedge clk);
      #1 chk_outputs_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // Basic single shot; a second I_single while busy must be ignored.
      do_run(32'd50_000, 32'd1_000, 5, 1'b0, 1'b1, 1'b1, 1'b0, c0);
      pulse_single();
      finish_run(300);
      repeat (20) @(negedge clk);
      chk("single_ignored_busy", 64'(O_busy), 64'd0);

      // Stale done held 6 cycles past start.
      do_run(32'd50_000_000, 32'd12_345, 6, 1'b0, 1'b1, 1'b1, 1'b0, c0);
      finish_run(300);

      // fx accumulator wraps.
      fx = 32'hFFFF_FF00;
      do_run(32'd50_000_000, 32'd512, 4, 1'b0, 1'b1, 1'b1, 1'b0, c0);
      finish_run(300);

      // dF0 == 0.
      do_run(32'd0, 32'd77, 4, 1'b0, 1'b1, 1'b1, 1'b0, c0);
      finish_run(300);

      // Done never arrives.
      do_run(32'd1_000, 32'd10, 4, 1'b1, 1'b1, 1'b1, 1'b0, c0);
      wait_valid(2000, ok);
      chk("timeout_valid_seen", 64'(ok), 64'd1);
      chk("timeout_latency_ok", 64'((cyc - c0) >= 995 && (cyc - c0) <= 1005), 64'd1);
      wait_idle(ok);
      chk("idle_after_timeout", 64'(ok), 64'd1);

      // Randomized runs, including small dF0 that saturates.
      for (int i = 0; i < 6; i++) begin
         if ($urandom_range(0, 2) == 0) rdf0 = 32'($urandom_range(1, 1000));
         else                           rdf0 = 32'($urandom_range(1, 100_000_000));
         do_run(rdf0, 32'($urandom), $urandom_range(4, 8), 1'b0, 1'b1, 1'b1, 1'b0, c0);
         finish_run(300);
      end

      // Continuous mode, dropped during the third run.
      cont = 1'b1;
      do_run(32'd50_000_000, 32'd100, 4, 1'b0, 1'b0, 1'b1, 1'b0, c0);
      do_run(32'd50_000_000, 32'd200, 4, 1'b0, 1'b0, 1'b1, 1'b0, c0);
      do_run(32'd50_000_000, 32'd300, 4, 1'b0, 1'b0, 1'b1, 1'b1, c0);
      wait_valid(300, ok);
      chk("cont_last_valid_seen", 64'(ok), 64'd1);
      repeat (3) @(negedge clk);
      chk("cont_stop_busy", 64'(O_busy), 64'd0);
      chk("cont_stop_start", 64'(O_meas_start), 64'd0);
      repeat (10) @(negedge clk);
      chk("cont_stays_idle", 64'(O_busy), 64'd0);

      // Reset while the divider is running.
      do_run(32'd50_000_000, 32'd999, 5, 1'b0, 1'b1, 1'b0, 1'b0, c0);
      repeat (2 + SETTLE + 1 + 20) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 chk_outputs_zero("reset_in_div");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (100) @(negedge clk);
      chk("no_post_after_reset", 64'(O_valid), 64'd0);
      do_run(32'd50_000, 32'd2_000, 5, 1'b0, 1'b1, 1'b1, 1'b0, c0);
      finish_run(300);

      repeat (20) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      chk("valid_count", 64'(n_valid), 64'(n_exp));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/freq_meas_ctrl.md
Name: freq_meas_ctrl

Overview:
- Sys-clock-domain initiator for the gated equal-precision frequency counter.
- Issues the counter's start request and waits for its done level.
- Computes per-measurement count deltas (the counter's outputs are free-running accumulators, cleared only by reset).
- Converts the deltas to Hz: freq = REF_HZ * dFx / dF0, rounded to nearest, using a sequential divider. Result feeds the display/UART reporting path.

Parameters:
- REF_HZ, 50_000_000, frequency of I_sys_clk in Hz (the counter's reference f0).
- START_W, 4, cycles O_meas_start is held high (≥2 required by the counter's edge detector).
- SETTLE_CYC, 8, sys cycles waited after synced done before sampling counts (fx-domain count settling).
- TIMEOUT_CYC, 100_000_000, max sys cycles from start to done before error; 0 disables.

Ports:
- I_sys_clk  in  1  system clock, REF_HZ.
- I_rst_n  in  1  async active-low reset.
- I_single  in  1  one-shot request; rising edge starts one measurement when idle.
- I_cont  in  1  continuous mode; while high, a new measurement starts as soon as the previous result is posted.
- O_meas_start  out  1  start request to the counter.
- I_meas_done  in  1  counter done level; contains an fx-domain term, so it is treated as asynchronous.
- I_f0_cnt  in  32  counter reference accumulator.
- I_fx_cnt  in  32  counter fx accumulator (fx domain; read only after settling).
- O_freq_hz  out  32  last measured frequency in Hz.
- O_valid  out  1  one-cycle pulse when O_freq_hz/O_err update.
- O_err  out  1  status of last result: dF0==0, timeout, or saturation.
- O_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, I_rst_n=0): all outputs 0, FSM to IDLE, timers, snapshot registers and synchronizers cleared. Reset mid-measurement aborts without an O_valid.
- I_meas_done passes through a 2-flop synchronizer (done_s). I_single is edge-detected in sys domain.
- FSM states:
  - IDLE: leave on I_single rise or I_cont=1 → SNAP.
  - SNAP (1 cycle): prev_f0←I_f0_cnt, prev_fx←I_fx_cnt; → START.
  - START: O_meas_start=1 for START_W cycles; → WAIT_LO.
  - WAIT_LO: wait done_s==0. The done left over from the previous run stays high for several cycles after start; it must not be taken as completion. → WAIT_HI.
  - WAIT_HI: wait done_s==1; → SETTLE.
  - SETTLE: SETTLE_CYC cycles; → CALC.
  - CALC (1 cycle): dF0=I_f0_cnt−prev_f0 and dFx=I_fx_cnt−prev_fx, both mod 2^32 so wrap-around is correct. num = REF_HZ*dFx (64-bit) + (dF0>>1). If dF0==0 → POST with err. Otherwise launch the divider → DIV.
  - DIV: wait divider done (64 cycles); → POST.
  - POST (1 cycle): O_valid=1; update O_freq_hz and O_err. → SNAP if I_cont, else IDLE.
- Timeout: a single counter runs from entering START to leaving WAIT_HI. Reaching TIMEOUT_CYC → POST with O_err=1, O_freq_hz=0.
- Saturation: if quotient > 0xFFFF_FFFF, O_freq_hz=0xFFFF_FFFF and O_err=1.
- dF0==0: O_freq_hz=0, O_err=1.
- I_cont falling mid-measurement: the current run completes and posts, then FSM goes to IDLE. I_single edges while busy are ignored (not queued).
- O_freq_hz and O_err hold between posts.
- Latency after done_s rises: SETTLE_CYC + 1 + 64 + 1 cycles (plus divider start/handshake cycle as implemented; fixed and documented in RTL header).

Decomposition:
- Shared package: FSM state encoding, divider width constant (64/32), error-cause codes.
- Sub-module seq_div_u64: restoring divider, 64-bit dividend / 32-bit divisor.
  - Ports: clk, rst_n, start, dividend, divisor, busy, done (1-cycle), quotient[63:0].
  - 64 iterations, one bit per cycle.

Test Plan:
- Counter model, REF_HZ=50_000_000; single shot with dF0=50_000, dFx=1_000 → O_freq_hz=1_000_000, O_err=0, exactly one O_valid.
- Stale done: I_meas_done held high for 6 cycles after start, then low, then high → exactly one result, computed from the second high.
- Wrap: prev_fx=0xFFFF_FF00, final 0x0000_0100, dF0=50_000_000 → dFx=512, O_freq_hz=512.
- dF0=0 → O_freq_hz=0, O_err=1. Separately, done never asserts with TIMEOUT_CYC=1000 → O_valid at ~1000 cycles, O_err=1.
- I_cont=1 across 3 runs with dFx=100, 200, 300 and dF0=50_000_000 → results 100, 200, 300 Hz. Drop I_cont in run 3 → FSM returns to IDLE after that post.
- Reset asserted in DIV → all outputs 0 immediately, no O_valid; a new I_single then measures normally.
